// File: rtl/prefetch_fetch_unit_pkg.sv
// Shared fetch definitions: instruction size constants and the length
// decoder. The decoder is also used by the Processor's own decode logic.
package prefetch_fetch_unit_pkg;

    localparam logic [1:0] INSTR_SIZE_1 = 2'd1;
    localparam logic [1:0] INSTR_SIZE_2 = 2'd2;
    localparam logic [1:0] INSTR_SIZE_3 = 2'd3;

    // Instruction length is a function of the opcode's low nibble only.
    function automatic logic [1:0] instrSizeOf(input logic [3:0] opcode_lo);
        if (opcode_lo[3:1] == 3'b111) begin
            return INSTR_SIZE_1;
        end else if ((opcode_lo[3:2] == 2'b01) || (opcode_lo == 4'hD)) begin
            return INSTR_SIZE_3;
        end else begin
            return INSTR_SIZE_2;
        end
    endfunction

endpackage

// File: rtl/prefetch_queue.sv
// Circular byte buffer for the instruction prefetcher.
// One byte may be pushed per cycle; 1..3 bytes may be popped per cycle.
// peek always shows the three bytes starting at the read pointer; bytes
// beyond count are stale and must be ignored by the consumer.
// flush empties the queue in one cycle by snapping rdPtr to wrPtr.
module prefetch_queue
    import prefetch_fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    input  logic [1:0]       pop_n,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [23:0]      peek
);

    logic [7:0]       buf_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_1;
    logic [PTR_W-1:0] rd_ptr_2;
    logic             push_fire;

    // Pointer advance modulo DEPTH; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                                 input logic [1:0]       n);
        logic [PTR_W:0] sum;
        sum = {1'b0, ptr} + {{(PTR_W - 1){1'b0}}, n};
        if (sum >= (PTR_W + 1)'(DEPTH)) begin
            sum = sum - (PTR_W + 1)'(DEPTH);
        end
        return sum[PTR_W-1:0];
    endfunction

    assign push_fire = push && !flush;
    assign rd_ptr_1  = ptr_add(rd_ptr_q, 2'd1);
    assign rd_ptr_2  = ptr_add(rd_ptr_q, 2'd2);

    // Next pointer/count: flush wins over push and pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push_fire) begin
                wr_ptr_d = ptr_add(wr_ptr_q, 2'd1);
            end
            if (pop) begin
                rd_ptr_d = ptr_add(rd_ptr_q, pop_n);
            end
            count_d = count_q + CNT_W'(push_fire) - (pop ? CNT_W'(pop_n) : '0);
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Byte storage; contents are qualified by count so they need no reset.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            buf_q[wr_ptr_q] <= push_data;
        end
    end

    assign count = count_q;
    assign peek  = {buf_q[rd_ptr_q], buf_q[rd_ptr_1], buf_q[rd_ptr_2]};

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Instruction fetch front-end: keeps a DEPTH-byte prefetch queue filled
// from synchronous-read program memory and presents whole 1/2/3-byte
// instructions to the execute stage. A jump flushes the queue and
// restarts fetching at the target; a read already in flight at the jump
// returns stale data that is dropped.
// Optional macro PREFETCH_TRACE_EN adds simulation-only take/jump trace
// messages; the synthesised logic is the same either way.
module prefetch_fetch_unit
    import prefetch_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memStrobe,
    input  logic [7:0]            memDataRead,
    output logic                  instrValid,
    output logic [23:0]           instrBytes,
    output logic [1:0]            instrSize,
    output logic [ADDR_WIDTH-1:0] instrPc,
    input  logic                  instrTake,
    input  logic                  jumpValid,
    input  logic [ADDR_WIDTH-1:0] jumpTarget
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] head_pc_q, head_pc_d;
    logic                  pending_q, pending_d;

    logic [CNT_W-1:0]      q_count;
    logic [23:0]           q_peek;
    logic [CNT_W:0]        occupancy;
    logic [1:0]            head_size;
    logic                  instr_valid;
    logic                  strobe;
    logic                  capture;
    logic                  take_fire;

    // Bytes held plus the one in flight; never let this exceed DEPTH so a
    // returning byte always has a free slot.
    assign occupancy   = {1'b0, q_count} + {{CNT_W{1'b0}}, pending_q};
    assign head_size   = instrSizeOf(q_peek[19:16]);
    assign instr_valid = (q_count >= CNT_W'(head_size));

    assign strobe    = !reset && !jumpValid && (occupancy < (CNT_W + 1)'(DEPTH));
    assign capture   = pending_q && !jumpValid;
    assign take_fire = instrTake && instr_valid && !jumpValid;

    prefetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data (memDataRead),
        .pop       (take_fire),
        .pop_n     (head_size),
        .flush     (jumpValid),
        .count     (q_count),
        .peek      (q_peek)
    );

    // Next fetch/head address and in-flight flag; a jump overrides all.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        pending_d  = 1'b0;
        if (jumpValid) begin
            fetch_pc_d = jumpTarget;
            head_pc_d  = jumpTarget;
        end else begin
            if (strobe) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
            end
            pending_d = strobe;
            if (take_fire) begin
                head_pc_d = head_pc_q + ADDR_WIDTH'(head_size);
            end
        end
    end

    // Address/control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            pending_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            pending_q  <= pending_d;
        end
    end

    assign memStrobe  = strobe;
    assign memAddr    = reset ? RESET_PC : fetch_pc_q;
    assign instrValid = instr_valid;
    assign instrBytes = q_peek;
    assign instrSize  = head_size;
    assign instrPc    = head_pc_q;

`ifdef PREFETCH_TRACE_EN
    // Simulation trace of consumed instructions and redirects.
    always_ff @(posedge clk) begin
        if (!reset && take_fire) begin
            $display("%h: %h size %0d", instrPc, instrBytes, instrSize);
        end
        if (!reset && jumpValid) begin
            $display("jump -> %h", jumpTarget);
        end
    end
`else
`endif

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Self-checking bench for prefetch_fetch_unit (ADDR_WIDTH=8, DEPTH=4).
// Reference model tracks only byte counts and addresses; instruction
// contents are read straight from the bench's memory image.
module tb_prefetch_fetch_unit;

    localparam int         AW    = 8;
    localparam int         DEPTH = 4;
    localparam logic [7:0] RPC   = 8'h00;

    logic        clk;
    logic        reset;
    logic [7:0]  memAddr;
    logic        memStrobe;
    logic [7:0]  memDataRead;
    logic        instrValid;
    logic [23:0] instrBytes;
    logic [1:0]  instrSize;
    logic [7:0]  instrPc;
    logic        instrTake;
    logic        jumpValid;
    logic [7:0]  jumpTarget;

    prefetch_fetch_unit #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .RESET_PC   (RPC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memAddr     (memAddr),
        .memStrobe   (memStrobe),
        .memDataRead (memDataRead),
        .instrValid  (instrValid),
        .instrBytes  (instrBytes),
        .instrSize   (instrSize),
        .instrPc     (instrPc),
        .instrTake   (instrTake),
        .jumpValid   (jumpValid),
        .jumpTarget  (jumpTarget)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit         m_init = 0;
    int         m_n = 0;
    int         m_p = 0;
    logic [7:0] m_f = 8'h00;
    logic [7:0] m_hp = 8'h00;

    // Last observed outputs
    bit         last_strobe = 0;
    logic [7:0] last_addr = 8'h00;
    bit         obs_valid;
    logic [7:0] obs_pc;
    logic [1:0] obs_sz;
    logic [23:0] obs_bytes;
    bit         obs_strobe;
    logic [7:0] obs_addr;

    int tq_pc [$];
    int tq_sz [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_size(input logic [7:0] b);
        case (b[3:0])
            4'hE, 4'hF:                    return 1;
            4'h4, 4'h5, 4'h6, 4'h7, 4'hD:  return 3;
            default:                       return 2;
        endcase
    endfunction

    // One clock cycle: drive inputs after the falling edge, compare
    // outputs against the model, then advance the model past the next
    // rising edge.
    task automatic step(input bit rst, input bit jv, input logic [7:0] jt, input bit tk);
        bit         e_strobe;
        bit         e_valid;
        bit         took;
        int         sz;
        logic [7:0] a1, a2;
        logic [23:0] e_bytes, mask;
        @(negedge clk);
        if (last_strobe) memDataRead = mem[last_addr];
        reset      = rst;
        jumpValid  = jv;
        jumpTarget = jt;
        instrTake  = tk;
        #1;
        sz = ref_size(mem[m_hp]);
        e_valid = m_init && (m_n >= sz);
        if (m_init) begin
            e_strobe = !rst && !jv && (m_n + m_p < DEPTH);
            check("memStrobe", memStrobe, e_strobe);
            if (e_strobe) check("memAddr", memAddr, m_f);
            check("instrValid", instrValid, e_valid);
            if (e_valid) begin
                a1 = m_hp + 8'd1;
                a2 = m_hp + 8'd2;
                e_bytes = {mem[m_hp], mem[a1], mem[a2]};
                mask = (sz == 1) ? 24'hFF0000 : (sz == 2) ? 24'hFFFF00 : 24'hFFFFFF;
                check("instrPc", instrPc, m_hp);
                check("instrSize", instrSize, sz);
                check("instrBytes", instrBytes & mask, e_bytes & mask);
            end
        end
        last_strobe = memStrobe;
        last_addr   = memAddr;
        obs_strobe  = memStrobe;
        obs_addr    = memAddr;
        obs_valid   = instrValid;
        obs_pc      = instrPc;
        obs_sz      = instrSize;
        obs_bytes   = instrBytes;
        // model update
        if (rst) begin
            m_init = 1;
            m_f = RPC; m_hp = RPC; m_n = 0; m_p = 0;
        end else if (jv) begin
            m_f = jt; m_hp = jt; m_n = 0; m_p = 0;
        end else begin
            e_strobe = (m_n + m_p < DEPTH);
            took = tk && e_valid;
            if (took) begin
                tq_pc.push_back(int'(m_hp));
                tq_sz.push_back(sz);
            end
            m_n = m_n + m_p - (took ? sz : 0);
            if (took) m_hp = m_hp + 8'(sz);
            if (e_strobe) m_f = m_f + 8'd1;
            m_p = e_strobe ? 1 : 0;
        end
    endtask

    task automatic load_plan_image();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h00] = 8'hFF;
        mem[8'h01] = 8'h0C; mem[8'h02] = 8'h42;
        mem[8'h03] = 8'h8D; mem[8'h04] = 8'h00; mem[8'h05] = 8'h20;
        mem[8'h20] = 8'h0C; mem[8'h21] = 8'h42;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int strobes;
        int maxaddr;
        int k;
        bit found;
        reset = 1; jumpValid = 0; jumpTarget = 0; instrTake = 0; memDataRead = 0;
        load_plan_image();

        // Reset state and in-order instruction stream
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_valid", obs_valid, 0);
        check("rst_strobe", obs_strobe, 0);
        tq_pc.delete(); tq_sz.delete();
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1);
        check("a_ntakes_ge3", tq_pc.size() >= 3, 1);
        if (tq_pc.size() >= 3) begin
            check("a_pc0", tq_pc[0], 32'h00); check("a_sz0", tq_sz[0], 1);
            check("a_pc1", tq_pc[1], 32'h01); check("a_sz1", tq_sz[1], 2);
            check("a_pc2", tq_pc[2], 32'h03); check("a_sz2", tq_sz[2], 3);
        end

        // Full queue stalls strobes; first take restarts them
        step(1, 0, 0, 0);
        strobes = 0; maxaddr = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            if (obs_strobe) begin
                strobes++;
                if (int'(obs_addr) > maxaddr) maxaddr = int'(obs_addr);
            end
        end
        check("full_strobes", strobes, 4);
        check("full_maxaddr", maxaddr, 3);
        step(0, 0, 0, 1);
        check("full_take_strobe", obs_strobe, 0);
        check("full_take_valid", obs_valid, 1);
        step(0, 0, 0, 0);
        check("resume_strobe", obs_strobe, 1);
        check("resume_addr", obs_addr, 8'h04);

        // Jump while the read of 0x05 is in flight
        step(1, 0, 0, 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (last_strobe && last_addr == 8'h05) found = 1;
            else step(0, 0, 0, 1);
        end
        check("pending05_found", found, 1);
        step(0, 1, 8'h20, 1);
        check("jump_no_strobe", obs_strobe, 0);
        step(0, 0, 0, 1);
        check("jump_first_strobe", obs_strobe, 1);
        check("jump_first_addr", obs_addr, 8'h20);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(0, 0, 0, 1);
            if (obs_valid) found = 1;
        end
        check("jump_valid_seen", found, 1);
        check("jump_pc", obs_pc, 8'h20);

        // Address wrap: 3-byte instruction straddling FF -> 00
        step(1, 0, 0, 0);
        mem[8'hFF] = 8'h8D; mem[8'h00] = 8'h00; mem[8'h01] = 8'h10;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 8'hFF, 0);
        step(0, 0, 0, 1);
        check("wrap_addr0", obs_addr, 8'hFF);
        step(0, 0, 0, 1);
        check("wrap_addr1", obs_addr, 8'h00);
        k = 2; found = 0;
        while (k < 12 && !found) begin
            step(0, 0, 0, 1);
            k++;
            if (obs_valid) found = 1;
        end
        check("wrap_latency", k, 5);
        check("wrap_pc", obs_pc, 8'hFF);
        check("wrap_size", obs_sz, 3);
        check("wrap_bytes", obs_bytes, 24'h8D0010);

        // Reset with non-empty queue and a read in flight
        step(1, 0, 0, 0);
        mem[8'h00] = 8'hFF; mem[8'h01] = 8'h0C;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        check("mid_pending", last_strobe, 1);
        step(1, 0, 0, 0);
        check("mid_rst_strobe", obs_strobe, 0);
        step(0, 0, 0, 0);
        check("mid_post_valid", obs_valid, 0);
        check("mid_post_strobe", obs_strobe, 1);
        check("mid_post_addr", obs_addr, RPC);

        // Take while only the first byte of a 2-byte instruction is held
        step(1, 0, 0, 0);
        step(0, 1, 8'h01, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("partial_valid", obs_valid, 0);
        check("partial_pc", obs_pc, 8'h01);
        step(0, 0, 0, 1);
        check("partial_later_valid", obs_valid, 1);
        check("partial_later_pc", obs_pc, 8'h01);
        check("partial_later_size", obs_sz, 2);

        // Randomised traffic
        step(1, 0, 0, 0);
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        step(1, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 100) == 0, ($urandom % 16) == 0, 8'($urandom), ($urandom % 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
